uart_tx_ctrl: RTL and testbench

- Framing controller for the UART transmitter. It accepts a parallel byte from the upstream register or FIFO, drives the serializer's load, and sequences start, data, optional parity and stop bits onto the TX line.
- Sits directly upstream of the serializer:
  - drives its p_data and ser_en;
  - consumes its ser_data and ser_done;
  - owns the tx_out line mux.
- One bit per clk; clk is the baud-rate clock.

---
 rtl/uart_tx_ctrl.sv | 212 +++++++++++++++++++++
 tb/tb_uart_tx_ctrl.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_ctrl.sv
// -----------------------------------------------------------------------------
// uart_tx_ctrl
// Framing controller for the UART transmitter. It accepts a parallel word from
// upstream, loads it into the serializer and sequences start, data, optional
// parity and stop bits onto the TX line. One bit is sent per clk (the
// baud-rate clock).
//
// Optional feature: define UART_TX_TWO_STOP_EN to add the stop2 input and a
// second stop bit (STOP2 state) selectable per frame.
//
// Ports:
//   clk         in   baud-rate clock, rising edge
//   rst         in   synchronous active-high reset
//   data_in     in   parallel word from upstream
//   data_valid  in   data_in valid; accepted only in IDLE or the last stop bit
//   par_en      in   1 = append parity bit (sampled at accept)
//   par_typ     in   0 = even, 1 = odd parity (sampled at accept)
//   stop2       in   1 = two stop bits (only with UART_TX_TWO_STOP_EN)
//   ser_data    in   current data bit from the serializer
//   ser_done    in   serializer last-data-bit flag
//   p_data      out  registered word presented to the serializer
//   ser_en      out  serializer load strobe (START only)
//   tx_out      out  UART TX line, idle high
//   busy        out  frame in progress
// -----------------------------------------------------------------------------
module uart_tx_ctrl #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  data_valid,
    input  logic                  par_en,
    input  logic                  par_typ,
`ifdef UART_TX_TWO_STOP_EN
    input  logic                  stop2,
`endif
    input  logic                  ser_data,
    input  logic                  ser_done,
    output logic [DATA_WIDTH-1:0] p_data,
    output logic                  ser_en,
    output logic                  tx_out,
    output logic                  busy
);

`ifdef UART_TX_TWO_STOP_EN
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_STOP2  = 3'd5
    } state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;
`endif

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
    logic                  par_q, par_d;
    logic                  par_en_q, par_en_d;
    logic                  par_typ_q, par_typ_d;
    logic                  accept_s;
`ifdef UART_TX_TWO_STOP_EN
    logic                  stop2_q, stop2_d;
`endif

    // Parity bit of a word: XOR of all bits, inverted for odd parity.
    function automatic logic parity_f(input logic [DATA_WIDTH-1:0] d,
                                      input logic                  odd);
        return (^d) ^ odd;
    endfunction

    // Accept window: IDLE or the final stop bit of the current frame.
    always_comb begin
        accept_s = 1'b0;
`ifdef UART_TX_TWO_STOP_EN
        if (state_q == ST_IDLE || state_q == ST_STOP2 ||
            (state_q == ST_STOP && !stop2_q)) begin
            accept_s = data_valid;
        end else begin
            accept_s = 1'b0;
        end
`else
        if (state_q == ST_IDLE || state_q == ST_STOP) begin
            accept_s = data_valid;
        end else begin
            accept_s = 1'b0;
        end
`endif
    end

    // Frame-attribute capture: word, parity and options are frozen at accept.
    always_comb begin
        p_data_d  = p_data_q;
        par_d     = par_q;
        par_en_d  = par_en_q;
        par_typ_d = par_typ_q;
`ifdef UART_TX_TWO_STOP_EN
        stop2_d   = stop2_q;
`endif
        if (accept_s) begin
            p_data_d  = data_in;
            par_d     = parity_f(data_in, par_typ);
            par_en_d  = par_en;
            par_typ_d = par_typ;
`ifdef UART_TX_TWO_STOP_EN
            stop2_d   = stop2;
`endif
        end else begin
            p_data_d  = p_data_q;
        end
    end

    // Next-state and line decode; tx_out is a pure mux so it has no latency.
    always_comb begin
        state_d = state_q;
        tx_out  = 1'b1;
        busy    = 1'b1;
        ser_en  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                busy = 1'b0;
                if (accept_s) begin
                    state_d = ST_START;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                tx_out  = 1'b0;
                ser_en  = 1'b1;
                state_d = ST_DATA;
            end
            ST_DATA: begin
                tx_out = ser_data;
                if (ser_done) begin
                    state_d = par_en_q ? ST_PARITY : ST_STOP;
                end else begin
                    state_d = ST_DATA;
                end
            end
            ST_PARITY: begin
                tx_out  = par_q;
                state_d = ST_STOP;
            end
            ST_STOP: begin
`ifdef UART_TX_TWO_STOP_EN
                if (stop2_q) begin
                    state_d = ST_STOP2;
                end else if (accept_s) begin
                    state_d = ST_START;
                end else begin
                    state_d = ST_IDLE;
                end
`else
                if (accept_s) begin
                    state_d = ST_START;
                end else begin
                    state_d = ST_IDLE;
                end
`endif
            end
`ifdef UART_TX_TWO_STOP_EN
            ST_STOP2: begin
                if (accept_s) begin
                    state_d = ST_START;
                end else begin
                    state_d = ST_IDLE;
                end
            end
`endif
            default: begin
                busy    = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and frame-attribute registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            p_data_q  <= {DATA_WIDTH{1'b0}};
            par_q     <= 1'b0;
            par_en_q  <= 1'b0;
            par_typ_q <= 1'b0;
`ifdef UART_TX_TWO_STOP_EN
            stop2_q   <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            p_data_q  <= p_data_d;
            par_q     <= par_d;
            par_en_q  <= par_en_d;
            par_typ_q <= par_typ_d;
`ifdef UART_TX_TWO_STOP_EN
            stop2_q   <= stop2_d;
`endif
        end
    end

    assign p_data = p_data_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_ctrl
// Directed bench for uart_tx_ctrl with a behavioural serializer. Single-frame
// vectors come from a table of hand-computed frames; back-to-back, mid-frame
// reset and (optionally) two-stop-bit cases are hand-written sequences.
// Expected frames are written left-aligned, cycle 0 (start bit) in bit 31.
// -----------------------------------------------------------------------------
module tb_uart_tx_ctrl;

    logic       clk;
    logic       rst;
    logic [7:0] data_in;
    logic       data_valid;
    logic       par_en;
    logic       par_typ;
    logic       stop2;
    logic       ser_data;
    logic       ser_done;
    logic [7:0] p_data;
    logic       ser_en;
    logic       tx_out;
    logic       busy;

    int n_chk  = 0;
    int n_fail = 0;

    uart_tx_ctrl #(.DATA_WIDTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .data_in    (data_in),
        .data_valid (data_valid),
        .par_en     (par_en),
        .par_typ    (par_typ),
`ifdef UART_TX_TWO_STOP_EN
        .stop2      (stop2),
`endif
        .ser_data   (ser_data),
        .ser_done   (ser_done),
        .p_data     (p_data),
        .ser_en     (ser_en),
        .tx_out     (tx_out),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural serializer: loads p_data on ser_en, shifts LSB first.
    logic [7:0] sh_r;
    logic [3:0] cnt_r;
    logic       act_r;
    always @(posedge clk) begin
        if (rst) begin
            sh_r  <= 8'd0;
            cnt_r <= 4'd0;
            act_r <= 1'b0;
        end else if (ser_en) begin
            sh_r  <= p_data;
            cnt_r <= 4'd0;
            act_r <= 1'b1;
        end else if (act_r) begin
            sh_r  <= sh_r >> 1;
            cnt_r <= cnt_r + 4'd1;
            if (cnt_r == 4'd7) act_r <= 1'b0;
        end
    end
    assign ser_data = sh_r[0];
    assign ser_done = act_r && (cnt_r == 4'd7);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_idle(input string name);
        chk({name, ".tx_out"}, {31'd0, tx_out}, 32'd1);
        chk({name, ".busy"},   {31'd0, busy},   32'd0);
        chk({name, ".ser_en"}, {31'd0, ser_en}, 32'd0);
    endtask

    // Present a word in IDLE, then check every cycle of the expected stream.
    // At cycle 0 the inputs switch to the *2 values; valid drops at drop_at.
    task automatic run_frame(input string name,
                             input logic [7:0] d,  input logic pe,  input logic pt,  input logic s2,
                             input logic [7:0] d2, input logic pe2, input logic pt2, input logic s22,
                             input int len, input logic [31:0] frame, input logic [31:0] en_mask,
                             input int drop_at);
        @(negedge clk);
        data_in = d; par_en = pe; par_typ = pt; stop2 = s2; data_valid = 1'b1;
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            if (i == 0) begin
                data_in = d2; par_en = pe2; par_typ = pt2; stop2 = s22;
            end
            if (i == drop_at) data_valid = 1'b0;
            chk($sformatf("%s.tx[%0d]", name, i),     {31'd0, tx_out}, {31'd0, frame[31-i]});
            chk($sformatf("%s.busy[%0d]", name, i),   {31'd0, busy},   32'd1);
            chk($sformatf("%s.ser_en[%0d]", name, i), {31'd0, ser_en}, {31'd0, en_mask[31-i]});
        end
        @(negedge clk);
        chk_idle({name, ".after"});
    endtask

    typedef struct {
        logic [7:0]  data;
        logic        pe;
        logic        pt;
        int          len;
        logic [31:0] frame;
    } vec_t;

    vec_t vecs[8];
    localparam logic [31:0] EN_ONE = {1'b1, 31'd0};

    initial begin
        vecs[0] = '{8'hA5, 1'b0, 1'b0, 10, {1'b0, 8'b10100101, 1'b1, 22'd0}};
        vecs[1] = '{8'hA5, 1'b1, 1'b0, 11, {1'b0, 8'b10100101, 1'b0, 1'b1, 21'd0}};
        vecs[2] = '{8'hA5, 1'b1, 1'b1, 11, {1'b0, 8'b10100101, 1'b1, 1'b1, 21'd0}};
        vecs[3] = '{8'h01, 1'b1, 1'b0, 11, {1'b0, 8'b10000000, 1'b1, 1'b1, 21'd0}};
        vecs[4] = '{8'h01, 1'b1, 1'b1, 11, {1'b0, 8'b10000000, 1'b0, 1'b1, 21'd0}};
        vecs[5] = '{8'h80, 1'b0, 1'b0, 10, {1'b0, 8'b00000001, 1'b1, 22'd0}};
        vecs[6] = '{8'h00, 1'b1, 1'b0, 11, {1'b0, 8'b00000000, 1'b0, 1'b1, 21'd0}};
        vecs[7] = '{8'hFF, 1'b1, 1'b1, 11, {1'b0, 8'b11111111, 1'b1, 1'b1, 21'd0}};

        rst = 1'b1; data_in = 8'd0; data_valid = 1'b0;
        par_en = 1'b0; par_typ = 1'b0; stop2 = 1'b0;
        @(negedge clk);
        chk_idle("reset");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk_idle("post_reset");

        // Table vectors; inputs are scrambled right after accept to prove the
        // frame uses only the captured values.
        for (int v = 0; v < 8; v++) begin
            run_frame($sformatf("vec%0d", v),
                      vecs[v].data, vecs[v].pe, vecs[v].pt, 1'b0,
                      ~vecs[v].data, ~vecs[v].pe, ~vecs[v].pt, 1'b0,
                      vecs[v].len, vecs[v].frame, EN_ONE, 0);
        end

        // Mid-frame data change to 0x3C does not disturb a 0xA5 frame.
        run_frame("chg3c", 8'hA5, 1'b0, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b0, 1'b0,
                  10, {1'b0, 8'b10100101, 1'b1, 22'd0}, EN_ONE, 0);

        // Back-to-back: valid held, 0x00 then 0xFF accepted in STOP.
        run_frame("b2b", 8'h00, 1'b0, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0,
                  20, {1'b0, 8'h00, 1'b1, 1'b0, 8'hFF, 1'b1, 12'd0},
                  {1'b1, 9'd0, 1'b1, 21'd0}, 10);

        // Reset during data bit 3 aborts the frame.
        @(negedge clk);
        data_in = 8'hA5; par_en = 1'b0; par_typ = 1'b0; data_valid = 1'b1;
        @(negedge clk);
        data_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("rst_mid.bit3", {31'd0, tx_out}, 32'd0);
        chk("rst_mid.busy", {31'd0, busy},   32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk_idle("rst_mid.abort");
        rst = 1'b0;
        @(negedge clk);
        chk_idle("rst_mid.idle");
        run_frame("after_rst", 8'h55, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0,
                  10, {1'b0, 8'b10101010, 1'b1, 22'd0}, EN_ONE, 0);

`ifdef UART_TX_TWO_STOP_EN
        // Two stop bits, single frame.
        run_frame("stop2", 8'hA5, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0,
                  11, {1'b0, 8'b10100101, 1'b1, 1'b1, 21'd0}, EN_ONE, 0);
        // Valid held: second frame must not start before STOP2 ends.
        run_frame("stop2_b2b", 8'hA5, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0,
                  21, {1'b0, 8'b10100101, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 11'd0},
                  {1'b1, 10'd0, 1'b1, 20'd0}, 11);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
